// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch stage and the pipeline registers around it.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        REQ,
        RESP,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] pc_plus4;
    } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with load/consume/flush; flush wins, load beats consume so
// a same-cycle consume+load keeps the stage valid.
module if_id_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  load_i,
    input  logic  consume_i,
    input  logic  flush_i,
    input  ifid_t data_i,
    output logic  valid_o,
    output ifid_t data_o
);

    logic  valid_q, valid_d;
    ifid_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    // Payload keeps its last value when invalid; consumers qualify with valid_o.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, fills IF/ID,
// and handles redirects by discarding any response still in flight.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               imem_rready,
    input  logic               redirect,
    input  logic [INSTR_W-1:0] redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [INSTR_W-1:0] if_pc,
    output logic [INSTR_W-1:0] if_pc_plus4
);

    localparam logic [INSTR_W-1:0] PC_STEP    = INSTR_W'(4);
    localparam logic [INSTR_W-1:0] ALIGN_MASK = ~INSTR_W'(3);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] pc_plus4;
    logic               accept;
    logic               consume;
    logic               load;
    ifid_t              ifid_in;
    ifid_t              ifid_out;

    assign pc_plus4    = pc_q + PC_STEP;
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign imem_rready = (state_q == RESP) ? (!if_valid || id_ready) : (state_q == DROP);
    assign accept      = imem_rvalid && imem_rready;
    assign consume     = if_valid && id_ready;
    assign load        = (state_q == RESP) && accept && !redirect;

    // Redirect overrides the PC; a request already granted must be drained in DROP.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            REQ: begin
                if (req_q && imem_gnt) begin
                    state_d = redirect ? DROP : RESP;
                end
            end
            RESP: begin
                if (accept) begin
                    state_d = REQ;
                    pc_d    = pc_plus4;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        if (redirect) begin
            pc_d = redirect_pc & ALIGN_MASK;
        end
        req_d = (state_d == REQ);
    end

    // req_q stays low through reset so nothing is requested until after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC & ALIGN_MASK;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
        end
    end

    assign ifid_in = '{instr: imem_rdata, pc: pc_q, pc_plus4: pc_plus4};

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (load),
        .consume_i (consume),
        .flush_i   (redirect),
        .data_i    (ifid_in),
        .valid_o   (if_valid),
        .data_o    (ifid_out)
    );

    assign if_instr    = ifid_out.instr;
    assign if_pc       = ifid_out.pc;
    assign if_pc_plus4 = ifid_out.pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus pushes expected
// fetch addresses and IF/ID contents; monitors pop and compare on handshakes.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_rready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        gnt_en      = 1'b0;
    logic        mem_pending = 1'b0;
    logic [31:0] mem_addr    = 32'h0;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          pop_cyc[$];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_rready (imem_rready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // lw r1 with the low address half as immediate, so each word is distinct.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return {6'b100011, 5'd0, 5'd1, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic [31:0] p4);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        e.pc4   = p4;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        mem_pending = 1'b0;
        #3;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_rready", 32'(imem_rready), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 50) begin
            @(negedge clk);
            #4;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending_ifid=%0d pending_addr=%0d exp=0", name, exp_q.size(), addr_q.size());
            exp_q.delete();
            addr_q.delete();
        end
    endtask

    // Memory: grants when gnt_en, answers one cycle later, holds rvalid until accepted.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            imem_gnt    = gnt_en;
            imem_rvalid = mem_pending;
            if (mem_pending) imem_rdata = instr_at(mem_addr);
            #1;
            if (imem_rvalid && imem_rready) mem_pending = 1'b0;
            if (imem_req && imem_gnt) begin
                mem_pending = 1'b1;
                mem_addr    = imem_addr;
            end
        end
    end

    // Monitor: compares IF/ID on consumption and imem_addr on each granted request.
    initial begin
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            #3;
            if (reset_n && if_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ifid_unexpected got_pc=%h exp=none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("ifid_instr", if_instr, e.instr);
                    chk("ifid_pc", if_pc, e.pc);
                    chk("ifid_pc_plus4", if_pc_plus4, e.pc4);
                    pop_cyc.push_back(cyc);
                end
            end
            if (reset_n && imem_req && imem_gnt) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL addr_unexpected got=%h exp=none", imem_addr);
                end else begin
                    a = addr_q.pop_front();
                    chk("imem_addr", imem_addr, a);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b1;
        id_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        @(negedge clk);

        // Reset, then straight-line fetch 0,4,8,C.
        gnt_en = 1'b1;
        pop_cyc.delete();
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        addr_q.push_back(32'hC);
        push_exp(32'h8C01_0000, 32'h0, 32'h4);
        push_exp(32'h8C01_0004, 32'h4, 32'h8);
        push_exp(32'h8C01_0008, 32'h8, 32'hC);
        push_exp(32'h8C01_000C, 32'hC, 32'h10);
        do_reset();
        @(negedge clk);
        #3;
        chk("t1_req_after_release", 32'(imem_req), 32'h1);
        chk("t1_addr_after_release", imem_addr, 32'h0);
        repeat (2) @(negedge clk);
        #3;
        chk("t2_first_valid", 32'(if_valid), 32'h1);
        chk("t2_opcode", 32'(if_instr[31:26]), 32'h23);
        repeat (5) @(negedge clk);
        gnt_en = 1'b0;
        wait_drain("t2");
        if (pop_cyc.size() >= 4) begin
            for (int i = 0; i < 3; i++) chk("t2_issue_gap", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd2);
        end else begin
            checks++;
            errors++;
            $display("FAIL t2_pop_count got=%0d exp=4", pop_cyc.size());
        end

        // Stall with pc=4 held in IF/ID.
        @(negedge clk);
        gnt_en = 1'b1;
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        push_exp(32'h8C01_0000, 32'h0, 32'h4);
        push_exp(32'h8C01_0004, 32'h4, 32'h8);
        push_exp(32'h8C01_0008, 32'h8, 32'hC);
        do_reset();
        repeat (5) @(negedge clk);
        id_ready = 1'b0;
        @(negedge clk);
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #3;
            chk("t3_stall_rready", 32'(imem_rready), 32'h0);
            chk("t3_stall_valid", 32'(if_valid), 32'h1);
            chk("t3_stall_pc", if_pc, 32'h4);
            chk("t3_stall_instr", if_instr, 32'h8C01_0004);
        end
        @(negedge clk);
        id_ready = 1'b1;
        #3;
        chk("t3_release_rready", 32'(imem_rready), 32'h1);
        wait_drain("t3");

        // Redirect while RESP is blocked by a stalled IF/ID.
        @(negedge clk);
        id_ready = 1'b0;
        gnt_en   = 1'b1;
        addr_q.push_back(32'hC);
        addr_q.push_back(32'h10);
        addr_q.push_back(32'h40);
        push_exp(32'h8C01_0040, 32'h40, 32'h44);
        repeat (3) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #3;
        chk("t4_valid_before", 32'(if_valid), 32'h1);
        chk("t4_rready_blocked", 32'(imem_rready), 32'h0);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        chk("t4_flushed", 32'(if_valid), 32'h0);
        chk("t4_drop_rready", 32'(imem_rready), 32'h1);
        chk("t4_drop_req", 32'(imem_req), 32'h0);
        @(negedge clk);
        #3;
        chk("t4_new_addr", imem_addr, 32'h40);
        chk("t4_new_req", 32'(imem_req), 32'h1);
        @(negedge clk);
        gnt_en = 1'b0;
        @(negedge clk);
        id_ready = 1'b1;
        wait_drain("t4");

        // Redirect in the same cycle as the response accept.
        @(negedge clk);
        gnt_en = 1'b1;
        addr_q.push_back(32'h44);
        addr_q.push_back(32'h100);
        push_exp(32'h8C01_0100, 32'h100, 32'h104);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        #3;
        chk("t5_accept_rready", 32'(imem_rready), 32'h1);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        chk("t5_no_load", 32'(if_valid), 32'h0);
        chk("t5_aligned_addr", imem_addr, 32'h100);
        chk("t5_req", 32'(imem_req), 32'h1);
        @(negedge clk);
        gnt_en = 1'b0;
        wait_drain("t5");

        // PC wrap, then async reset in the middle of RESP.
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        gnt_en   = 1'b1;
        addr_q.push_back(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        push_exp(32'h8C01_FFFC, 32'hFFFF_FFFC, 32'h0);
        #3;
        chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
        repeat (2) @(negedge clk);
        #3;
        chk("t6_wrap_plus4", if_pc_plus4, 32'h0);
        chk("t6_wrap_addr", imem_addr, 32'h0);
        @(negedge clk);
        addr_q.push_back(32'h0);
        push_exp(32'h8C01_0000, 32'h0, 32'h4);
        do_reset();
        @(negedge clk);
        #3;
        chk("t6_refetch_addr", imem_addr, 32'h0);
        chk("t6_refetch_req", 32'(imem_req), 32'h1);
        @(negedge clk);
        gnt_en = 1'b0;
        wait_drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
